dh_exchange_ctrl: RTL and testbench

// Initiator for the curve25519 scalar-multiplier start/done interface; drives one multiplier instance.

---
 rtl/dh_exchange_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_dh_exchange_ctrl.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dh_exchange_ctrl.sv
// ============================================================================
// dh_exchange_ctrl
// ----------------------------------------------------------------------------
// Key-exchange sequencer in front of a single curve25519 scalar multiplier.
// On request it computes our public key (secret * BASE_POINT). When a peer
// public key arrives it computes the shared key (secret * peer_pub). Only one
// multiplication runs at a time. A single-entry pending slot holds a peer
// request that arrives while the multiplier is in use.
//
// Parameters
//   TIMEOUT_CYCLES  max cycles spent waiting for mul_done before aborting
//   BASE_POINT      point used for public-key generation
//
// Compile-time option
//   DH_CLAMP_EN     when defined, the scalar sent to the multiplier (and the
//                   one held in the pending slot) is clamped: bits[2:0]=0,
//                   bit 254=1. When undefined the secret is used unmodified.
//
// Ports
//   clock, reset         system clock; asynchronous active-high reset
//   secret [254:0]       our scalar, sampled when a request is accepted
//   gen_pub              1-cycle request: compute public key
//   peer_valid           1-cycle strobe: peer_pub valid, compute shared key
//   peer_pub [254:0]     peer public key
//   mul_start            1-cycle start pulse to the multiplier
//   mul_n, mul_q         scalar / point to the multiplier, held during a job
//   mul_done, mul_out    multiplier completion and result
//   pub_key, pub_valid   last public key and its 1-cycle update strobe
//   shared_key, shared_valid  last shared key and its 1-cycle update strobe
//   busy                 high whenever not idle
//   timeout              1-cycle strobe when a wait is aborted
//   overflow             1-cycle strobe when a peer strobe is dropped
// ============================================================================
module dh_exchange_ctrl #(
    parameter int           TIMEOUT_CYCLES = 1024,
    parameter logic [254:0] BASE_POINT     = 255'd9
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [254:0] secret,
    input  logic         gen_pub,
    input  logic         peer_valid,
    input  logic [254:0] peer_pub,
    output logic         mul_start,
    output logic [254:0] mul_n,
    output logic [254:0] mul_q,
    input  logic         mul_done,
    input  logic [254:0] mul_out,
    output logic [254:0] pub_key,
    output logic         pub_valid,
    output logic [254:0] shared_key,
    output logic         shared_valid,
    output logic         busy,
    output logic         timeout,
    output logic         overflow
);

    localparam int            TW      = $clog2(TIMEOUT_CYCLES + 1);
    // Timer value at the start of the last permitted wait cycle.
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        PUB_START,
        PUB_WAIT,
        SEC_START,
        SEC_WAIT
    } state_t;

    state_t        state_reg, state_next;
    logic [TW-1:0] timer_reg, timer_next;
    logic [254:0]  mul_n_reg, mul_n_next;
    logic [254:0]  mul_q_reg, mul_q_next;
    logic          pend_valid_reg, pend_valid_next;
    logic [254:0]  pend_n_reg, pend_n_next;
    logic [254:0]  pend_q_reg, pend_q_next;
    logic [254:0]  pub_key_reg, pub_key_next;
    logic [254:0]  shared_key_reg, shared_key_next;
    logic          pub_valid_reg, pub_valid_next;
    logic          shared_valid_reg, shared_valid_next;
    logic          timeout_reg, timeout_next;
    logic          overflow_reg, overflow_next;

    // Scalar actually handed to the multiplier.
    logic [254:0]  secret_eff;

`ifdef DH_CLAMP_EN
    genvar gi;
    generate
        for (gi = 0; gi < 255; gi++) begin : g_clamp
            if (gi < 3) begin : g_low
                assign secret_eff[gi] = 1'b0;
            end else if (gi == 254) begin : g_top
                assign secret_eff[gi] = 1'b1;
            end else begin : g_mid
                assign secret_eff[gi] = secret[gi];
            end
        end
    endgenerate
`else
    assign secret_eff = secret;
`endif

    // ------------------------------------------------------------------
    // State and data registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg        <= IDLE;
            timer_reg        <= '0;
            mul_n_reg        <= '0;
            mul_q_reg        <= '0;
            pend_valid_reg   <= 1'b0;
            pend_n_reg       <= '0;
            pend_q_reg       <= '0;
            pub_key_reg      <= '0;
            shared_key_reg   <= '0;
            pub_valid_reg    <= 1'b0;
            shared_valid_reg <= 1'b0;
            timeout_reg      <= 1'b0;
            overflow_reg     <= 1'b0;
        end else begin
            state_reg        <= state_next;
            timer_reg        <= timer_next;
            mul_n_reg        <= mul_n_next;
            mul_q_reg        <= mul_q_next;
            pend_valid_reg   <= pend_valid_next;
            pend_n_reg       <= pend_n_next;
            pend_q_reg       <= pend_q_next;
            pub_key_reg      <= pub_key_next;
            shared_key_reg   <= shared_key_next;
            pub_valid_reg    <= pub_valid_next;
            shared_valid_reg <= shared_valid_next;
            timeout_reg      <= timeout_next;
            overflow_reg     <= overflow_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next        = state_reg;
        timer_next        = timer_reg;
        mul_n_next        = mul_n_reg;
        mul_q_next        = mul_q_reg;
        pend_valid_next   = pend_valid_reg;
        pend_n_next       = pend_n_reg;
        pend_q_next       = pend_q_reg;
        pub_key_next      = pub_key_reg;
        shared_key_next   = shared_key_reg;
        pub_valid_next    = 1'b0;
        shared_valid_next = 1'b0;
        timeout_next      = 1'b0;
        overflow_next     = 1'b0;
        mul_start         = 1'b0;

        // A peer strobe is served directly only from IDLE without a
        // competing gen_pub; otherwise it goes to the pending slot. The
        // slot never drains in a cycle that carries a peer strobe, so the
        // two writes below cannot collide.
        if (peer_valid && !(state_reg == IDLE && !gen_pub)) begin
            if (pend_valid_reg) begin
                overflow_next = 1'b1;          // keep the older request
            end else begin
                pend_valid_next = 1'b1;
                pend_n_next     = secret_eff;
                pend_q_next     = peer_pub;
            end
        end

        case (state_reg)
            IDLE: begin
                if (gen_pub) begin
                    mul_n_next = secret_eff;
                    mul_q_next = BASE_POINT;
                    state_next = PUB_START;
                end else if (peer_valid) begin
                    mul_n_next = secret_eff;
                    mul_q_next = peer_pub;
                    state_next = SEC_START;
                end else if (pend_valid_reg) begin
                    mul_n_next      = pend_n_reg;
                    mul_q_next      = pend_q_reg;
                    pend_valid_next = 1'b0;
                    state_next      = SEC_START;
                end
            end

            PUB_START, SEC_START: begin
                mul_start  = 1'b1;
                timer_next = '0;
                state_next = (state_reg == PUB_START) ? PUB_WAIT : SEC_WAIT;
            end

            PUB_WAIT, SEC_WAIT: begin
                if (mul_done) begin
                    if (state_reg == PUB_WAIT) begin
                        pub_key_next   = mul_out;
                        pub_valid_next = 1'b1;
                    end else begin
                        shared_key_next   = mul_out;
                        shared_valid_next = 1'b1;
                    end
                    state_next = IDLE;
                end else begin
                    timer_next = timer_reg + TW'(1);
                    // Abort at the end of the TIMEOUT_CYCLES-th wait cycle.
                    if (timer_reg == TO_LAST) begin
                        timeout_next = 1'b1;
                        state_next   = IDLE;
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign mul_n        = mul_n_reg;
    assign mul_q        = mul_q_reg;
    assign pub_key      = pub_key_reg;
    assign shared_key   = shared_key_reg;
    assign pub_valid    = pub_valid_reg;
    assign shared_valid = shared_valid_reg;
    assign timeout      = timeout_reg;
    assign overflow     = overflow_reg;
    assign busy         = (state_reg != IDLE);

endmodule

// File: tb/tb_dh_exchange_ctrl.sv
// ============================================================================
// tb_dh_exchange_ctrl
// ----------------------------------------------------------------------------
// Directed bench for dh_exchange_ctrl. A dummy multiplier answers each start
// pulse with n*q (mod 2^255) after a programmable latency. Each test pushes
// the multiplier jobs, key results and abort/drop events it expects into
// queues; one compare process checks every DUT output event against them
// on each falling edge. Hand-computed literals pin latency and key values.
// ============================================================================
module tb_dh_exchange_ctrl;

    localparam int TO = 16;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [254:0] secret = '0;
    logic         gen_pub = 1'b0;
    logic         peer_valid = 1'b0;
    logic [254:0] peer_pub = '0;
    logic         mul_start;
    logic [254:0] mul_n;
    logic [254:0] mul_q;
    logic         mul_done = 1'b0;
    logic [254:0] mul_out = '0;
    logic [254:0] pub_key;
    logic         pub_valid;
    logic [254:0] shared_key;
    logic         shared_valid;
    logic         busy;
    logic         timeout;
    logic         overflow;

    dh_exchange_ctrl #(
        .TIMEOUT_CYCLES(TO),
        .BASE_POINT    (255'd9)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .secret      (secret),
        .gen_pub     (gen_pub),
        .peer_valid  (peer_valid),
        .peer_pub    (peer_pub),
        .mul_start   (mul_start),
        .mul_n       (mul_n),
        .mul_q       (mul_q),
        .mul_done    (mul_done),
        .mul_out     (mul_out),
        .pub_key     (pub_key),
        .pub_valid   (pub_valid),
        .shared_key  (shared_key),
        .shared_valid(shared_valid),
        .busy        (busy),
        .timeout     (timeout),
        .overflow    (overflow)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    initial forever begin
        @(posedge clock);
        cyc <= cyc + 1;
    end

    // ------------------------------------------------------------------
    // Dummy multiplier: result n*q, mul_done LAT cycles after the start
    // cycle. Drives junk on mul_out whenever it is not done.
    // ------------------------------------------------------------------
    int           mul_lat = 3;
    bit           mac_active = 1'b0;
    int           mac_cnt = 0;
    logic [254:0] mac_n = '0, mac_q = '0;

    initial forever begin
        @(posedge clock);
        mul_done <= 1'b0;
        mul_out  <= 255'({$urandom, $urandom, $urandom, $urandom,
                          $urandom, $urandom, $urandom, $urandom});
        if (mul_start) begin
            mac_active <= 1'b1;
            mac_cnt    <= mul_lat - 1;
            mac_n      <= mul_n;
            mac_q      <= mul_q;
        end else if (mac_active) begin
            if (mac_cnt == 1) begin
                mul_done   <= 1'b1;
                mul_out    <= mac_n * mac_q;
                mac_active <= 1'b0;
            end else begin
                mac_cnt <= mac_cnt - 1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Checking infrastructure
    // ------------------------------------------------------------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [254:0] act, input logic [254:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end else begin
            $display("ok   %s = %h", nm, act);
        end
    endtask

    // Transaction-level model: expected jobs and results, in order.
    typedef struct {
        logic [254:0] n;
        logic [254:0] q;
    } job_t;

    job_t         exp_jobs[$];
    logic [254:0] exp_pub[$];
    logic [254:0] exp_sh[$];
    int           exp_ovf = 0;
    int           exp_to  = 0;

    function automatic logic [254:0] model_scalar(input logic [254:0] s);
        logic [254:0] r;
        r = s;
`ifdef DH_CLAMP_EN
        r[2:0] = 3'b000;
        r[254] = 1'b1;
`endif
        return r;
    endfunction

    task automatic expect_job(input logic [254:0] s, input logic [254:0] q);
        job_t j;
        j.n = model_scalar(s);
        j.q = q;
        exp_jobs.push_back(j);
    endtask

    task automatic expect_pub(input logic [254:0] s);
        logic [254:0] n;
        n = model_scalar(s);
        expect_job(s, 255'd9);
        exp_pub.push_back(n * 255'd9);
    endtask

    task automatic expect_shared(input logic [254:0] s, input logic [254:0] p);
        logic [254:0] n;
        n = model_scalar(s);
        expect_job(s, p);
        exp_sh.push_back(n * p);
    endtask

    function automatic int outstanding();
        return exp_jobs.size() + exp_pub.size() + exp_sh.size() + exp_ovf + exp_to;
    endfunction

    // ------------------------------------------------------------------
    // Compare process
    // ------------------------------------------------------------------
    int           last_start = -1, last_pub = -1, last_shared = -1, last_to = -1;
    int           n_start = 0, n_pub = 0, n_sh = 0, n_ovf = 0, n_to = 0;
    logic [254:0] last_start_n = '0, last_start_q = '0;
    job_t         cur;
    bit           job_active = 1'b0;

    initial forever begin
        @(negedge clock);
        if (reset) begin
            job_active = 1'b0;
        end else begin
            if (mul_start) begin
                n_start++;
                last_start   = cyc;
                last_start_n = mul_n;
                last_start_q = mul_q;
                chk("mul_start_expected", exp_jobs.size() > 0, 1'b1);
                if (exp_jobs.size() > 0) begin
                    cur = exp_jobs.pop_front();
                    chk("mul_n", mul_n, cur.n);
                    chk("mul_q", mul_q, cur.q);
                    job_active = 1'b1;
                end
            end else if (job_active) begin
                chk("mul_n_hold", mul_n, cur.n);
                chk("mul_q_hold", mul_q, cur.q);
            end
            if (mul_done) job_active = 1'b0;

            if (pub_valid) begin
                n_pub++;
                last_pub = cyc;
                chk("pub_valid_expected", exp_pub.size() > 0, 1'b1);
                if (exp_pub.size() > 0) chk("pub_key", pub_key, exp_pub.pop_front());
            end
            if (shared_valid) begin
                n_sh++;
                last_shared = cyc;
                chk("shared_valid_expected", exp_sh.size() > 0, 1'b1);
                if (exp_sh.size() > 0) chk("shared_key", shared_key, exp_sh.pop_front());
            end
            if (overflow) begin
                n_ovf++;
                chk("overflow_expected", exp_ovf > 0, 1'b1);
                if (exp_ovf > 0) exp_ovf--;
            end
            if (timeout) begin
                n_to++;
                last_to = cyc;
                job_active = 1'b0;
                chk("timeout_expected", exp_to > 0, 1'b1);
                if (exp_to > 0) exp_to--;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic drive(input logic gp, input logic pv,
                         input logic [254:0] s, input logic [254:0] p);
        @(posedge clock);
        #1;
        gen_pub    = gp;
        peer_valid = pv;
        secret     = s;
        peer_pub   = p;
    endtask

    task automatic wait_quiet(input string nm, input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clock);
            #1;
            if (outstanding() == 0 && !busy) break;
        end
        chk({nm, "_drained"}, outstanding(), 0);
        chk({nm, "_busy_low"}, busy, 1'b0);
    endtask

    // Global watchdog.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Directed tests
    // ------------------------------------------------------------------
    int           t0;
    int           c0;
    logic [254:0] top_bit;

    initial begin
        top_bit      = '0;
        top_bit[254] = 1'b1;

        // Reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_busy", busy, 1'b0);
        chk("rst_mul_start", mul_start, 1'b0);
        chk("rst_mul_n", mul_n, '0);
        chk("rst_mul_q", mul_q, '0);
        chk("rst_pub_key", pub_key, '0);
        chk("rst_shared_key", shared_key, '0);
        chk("rst_strobes", {pub_valid, shared_valid, timeout, overflow}, '0);
        @(posedge clock);
        #1 reset = 1'b0;

        // T1: public key, minimum latency
        expect_pub(255'd5);
        drive(1, 0, 255'd5, '0);
        t0 = cyc;
        drive(0, 0, 255'd5, '0);
        wait_quiet("t1", 40);
        chk("t1_start_cycle", last_start, t0 + 1);
        chk("t1_pub_cycle", last_pub, t0 + 5);
        chk("t1_mul_q_base", last_start_q, 255'd9);
`ifndef DH_CLAMP_EN
        chk("t1_mul_n_literal", last_start_n, 255'd5);
        chk("t1_pub_key_literal", pub_key, 255'd45);
`endif

        // T2: shared key straight from IDLE
        c0 = n_sh;
        expect_shared(255'd5, 255'd7);
        drive(0, 1, 255'd5, 255'd7);
        drive(0, 0, 255'd5, '0);
        wait_quiet("t2", 40);
        chk("t2_shared_once", n_sh - c0, 1);
`ifndef DH_CLAMP_EN
        chk("t2_shared_literal", shared_key, 255'd35);
`endif

        // T3: gen_pub and peer_valid together, public key first
        c0 = n_start;
        expect_pub(255'd3);
        expect_shared(255'd3, 255'd11);
        drive(1, 1, 255'd3, 255'd11);
        drive(0, 0, 255'd3, '0);
        wait_quiet("t3", 60);
        chk("t3_two_starts", n_start - c0, 2);
        chk("t3_pub_before_shared", last_pub < last_shared, 1'b1);
`ifndef DH_CLAMP_EN
        chk("t3_pub_literal", pub_key, 255'd27);
        chk("t3_shared_literal", shared_key, 255'd33);
`endif

        // T4: two peer strobes while busy -> one kept, one dropped;
        // gen_pub while busy is ignored.
        c0 = n_ovf;
        expect_pub(255'd5);
        expect_shared(255'd5, 255'd7);
        exp_ovf = 1;
        drive(1, 0, 255'd5, '0);
        drive(0, 0, 255'd5, '0);
        drive(1, 1, 255'd5, 255'd7);
        drive(0, 1, 255'd5, 255'd8);
        drive(0, 0, 255'd5, '0);
        wait_quiet("t4", 60);
        chk("t4_overflow_once", n_ovf - c0, 1);
`ifndef DH_CLAMP_EN
        chk("t4_shared_q7_literal", shared_key, 255'd35);
`endif

        // T5: multiplier too slow -> timeout, late mul_done ignored
        mul_lat = 40;
        c0 = n_pub;
        expect_job(255'd5, 255'd9);
        exp_to = 1;
        drive(1, 0, 255'd5, '0);
        t0 = cyc;
        drive(0, 0, 255'd5, '0);
        wait_quiet("t5", 60);
        chk("t5_timeout_cycle", last_to, t0 + 2 + TO);
        repeat (40) @(posedge clock);
        chk("t5_no_pub_strobe", n_pub - c0, 0);
        mul_lat = 3;

        // T6: reset during PUB_WAIT with a pending peer request
        c0 = n_pub + n_sh;
        expect_job(255'd5, 255'd9);
        drive(1, 0, 255'd5, '0);
        drive(0, 1, 255'd5, 255'd7);
        drive(0, 0, 255'd5, '0);
        reset = 1'b1;
        exp_pub.delete();
        @(negedge clock);
        chk("t6_rst_busy", busy, 1'b0);
        chk("t6_rst_pub_key", pub_key, '0);
        chk("t6_rst_mul_n", mul_n, '0);
        @(posedge clock);
        #1 reset = 1'b0;
        repeat (12) @(posedge clock);
        @(negedge clock);
        chk("t6_no_strobes", n_pub + n_sh - c0, 0);
        chk("t6_idle", busy, 1'b0);
        chk("t6_outstanding", outstanding(), 0);

        // T7: scalar handling at the multiplier port
        expect_pub(255'd7);
        drive(1, 0, 255'd7, '0);
        drive(0, 0, 255'd7, '0);
        wait_quiet("t7", 40);
`ifdef DH_CLAMP_EN
        chk("t7_clamped_n", last_start_n, top_bit);
`else
        chk("t7_raw_n", last_start_n, 255'd7);
`endif

        repeat (2) @(posedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
